bit_flip_counter_array: RTL and testbench

- Parametrised successor to the single 8-bit flip counter hung off the user-project GPIO pins.
- Synchronises a DATA_W-bit input bus and detects per-bit transitions, filtered by a selectable edge mode.
- Keeps one aggregate flip counter plus one counter per bit, with wrap or saturate arithmetic, sticky overflow and a snapshot handshake.
- Sits inside user_project_wrapper, fed from io_in, results on io_out/LA.

---
 rtl/bfc_pkg.sv | 44 ++++
 rtl/bfc_edge_detect.sv | 70 +++++++
 rtl/bit_flip_counter_array.sv | 138 +++++++++++++
 tb/tb_bit_flip_counter_array.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bfc_pkg.sv
// Shared definitions for bit_flip_counter_array.
// Holds the edge-mode encodings, a popcount helper and a wrap/saturate adder.
// Both helpers work at BFC_MAX_W bits; callers zero-extend narrower operands,
// so DATA_W and COUNT_W must not exceed BFC_MAX_W.
package bfc_pkg;

  localparam int unsigned BFC_MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_BOTH = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_HOLD = 2'b11
  } bfc_mode_e;

  // Number of set bits in i_vec.
  function automatic logic [BFC_MAX_W-1:0] bfc_popcount(input logic [BFC_MAX_W-1:0] i_vec);
    logic [BFC_MAX_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(BFC_MAX_W); i++) begin
      cnt = cnt + BFC_MAX_W'(i_vec[i]);
    end
    return cnt;
  endfunction

  // Returns {ovf, sum}; i_max is the all-ones value of the real counter width.
  // ovf is set whenever the true sum exceeds i_max, which also covers a
  // saturated counter receiving a non-zero increment.
  function automatic logic [BFC_MAX_W:0] bfc_add(input logic [BFC_MAX_W-1:0] i_cur,
                                                 input logic [BFC_MAX_W-1:0] i_inc,
                                                 input logic [BFC_MAX_W-1:0] i_max,
                                                 input logic                 i_sat);
    logic [BFC_MAX_W:0]   sum;
    logic                 ovf;
    logic [BFC_MAX_W-1:0] res;
    sum = {1'b0, i_cur} + {1'b0, i_inc};
    ovf = (sum > {1'b0, i_max});
    if (!ovf)       res = sum[BFC_MAX_W-1:0];
    else if (i_sat) res = i_max;
    else            res = sum[BFC_MAX_W-1:0] & i_max;
    return {ovf, res};
  endfunction

endpackage

// File: rtl/bfc_edge_detect.sv
// Input synchroniser and per-bit transition detector.
// Ports: clk, reset_n (async active-low), i_clear (drops priming, zeroes prev),
//        i_mode (edge mode), i_data (asynchronous bus),
//        o_flip_c (combinational masked flip vector, zero while unprimed).
// Priming waits until the synchroniser has flushed after reset, so a bus that
// is already non-zero at power-on is never counted as a flip.
module bfc_edge_detect #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_flip_c
);
  import bfc_pkg::*;

  logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sync;
  logic [SYNC_STAGES-1:0]             r_fill;
  logic [DATA_W-1:0]                  r_prev;
  logic                               r_primed;
  logic [DATA_W-1:0]                  w_s;
  logic [DATA_W-1:0]                  w_flip;
  logic                               w_filled;

  assign w_s      = r_sync[SYNC_STAGES-1];
  assign w_filled = r_fill[SYNC_STAGES-1];
  assign w_flip   = w_s ^ r_prev;

  // Synchroniser chain plus a marker that tracks when it holds real bus data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_fill <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_data};
      r_fill <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // prev follows s every cycle so re-enabling never counts stale edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
    end else if (i_clear) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
    end else begin
      r_prev <= w_s;
      if (w_filled) r_primed <= 1'b1;
    end
  end

  // Edge-mode masking.
  always_comb begin
    o_flip_c = '0;
    if (r_primed) begin
      case (bfc_mode_e'(i_mode))
        MODE_BOTH: o_flip_c = w_flip;
        MODE_RISE: o_flip_c = w_s & w_flip;
        MODE_FALL: o_flip_c = ~w_s & w_flip;
        default:   o_flip_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/bit_flip_counter_array.sv
// Aggregate and per-bit flip counters for a synchronised DATA_W-bit bus.
// Ports: clk, reset_n (async active-low), enable, clear, mode, saturate,
//        data_in, ch_sel -> total_count, ch_count, overflow;
//        snap_req -> snap_count, snap_valid; thresh -> irq.
// Optional: define BFC_THRESH_IRQ_EN to build the sticky threshold interrupt;
// otherwise irq is tied low and thresh is ignored.
module bit_flip_counter_array #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned COUNT_W     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                                           clk,
  input  logic                                           reset_n,
  input  logic                                           enable,
  input  logic                                           clear,
  input  logic [1:0]                                     mode,
  input  logic                                           saturate,
  input  logic [DATA_W-1:0]                              data_in,
  input  logic [((DATA_W > 1) ? $clog2(DATA_W) : 1)-1:0] ch_sel,
  output logic [COUNT_W-1:0]                             total_count,
  output logic [COUNT_W-1:0]                             ch_count,
  output logic                                           overflow,
  input  logic                                           snap_req,
  output logic [COUNT_W-1:0]                             snap_count,
  output logic                                           snap_valid,
  input  logic [COUNT_W-1:0]                             thresh,
  output logic                                           irq
);
  import bfc_pkg::*;

  localparam logic [BFC_MAX_W-1:0] CNT_MAX = BFC_MAX_W'({COUNT_W{1'b1}});

  logic [DATA_W-1:0]  w_flip_c;
  logic [COUNT_W-1:0] r_total;
  logic [COUNT_W-1:0] r_cnt [DATA_W];
  logic               r_ovf;
  logic [COUNT_W-1:0] r_ch_count;
  logic [COUNT_W-1:0] r_snap_count;
  logic               r_snap_valid;
  logic [BFC_MAX_W:0] w_tot_add;
  logic [BFC_MAX_W:0] w_ch_add [DATA_W];
  logic [COUNT_W-1:0] w_total_d;
  logic               w_any_ovf;
  logic               w_unused;

  bfc_edge_detect #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clear  (clear),
    .i_mode   (mode),
    .i_data   (data_in),
    .o_flip_c (w_flip_c)
  );

  // Adders for the aggregate and per-bit counters; unused high bits are folded away.
  always_comb begin
    w_tot_add = bfc_add(BFC_MAX_W'(r_total), bfc_popcount(BFC_MAX_W'(w_flip_c)), CNT_MAX, saturate);
    w_any_ovf = w_tot_add[BFC_MAX_W];
    w_unused  = ^w_tot_add;
    for (int i = 0; i < int'(DATA_W); i++) begin
      w_ch_add[i] = bfc_add(BFC_MAX_W'(r_cnt[i]), BFC_MAX_W'(w_flip_c[i]), CNT_MAX, saturate);
      w_any_ovf   = w_any_ovf | w_ch_add[i][BFC_MAX_W];
      w_unused    = w_unused ^ (^w_ch_add[i]);
    end
`ifndef BFC_THRESH_IRQ_EN
    w_unused = w_unused ^ (^thresh);
`endif
  end

  // Next aggregate value; clear has priority over counting.
  always_comb begin
    w_total_d = r_total;
    if (clear)       w_total_d = '0;
    else if (enable) w_total_d = w_tot_add[COUNT_W-1:0];
  end

  // Counters and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_total <= '0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < int'(DATA_W); i++) r_cnt[i] <= '0;
    end else begin
      r_total <= w_total_d;
      if (clear) begin
        r_ovf <= 1'b0;
        for (int i = 0; i < int'(DATA_W); i++) r_cnt[i] <= '0;
      end else if (enable) begin
        if (w_any_ovf) r_ovf <= 1'b1;
        for (int i = 0; i < int'(DATA_W); i++) r_cnt[i] <= w_ch_add[i][COUNT_W-1:0];
      end
    end
  end

  // Registered channel readout; out-of-range selects read as zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                     r_ch_count <= '0;
    else if (clear)                   r_ch_count <= '0;
    else if (32'(ch_sel) < DATA_W)    r_ch_count <= r_cnt[ch_sel];
    else                              r_ch_count <= '0;
  end

  // Snapshot captures the pre-update total, including on a clear edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_snap_count <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= snap_req;
      if (snap_req) r_snap_count <= r_total;
    end
  end

`ifdef BFC_THRESH_IRQ_EN
  logic r_irq;

  // Sticky threshold interrupt on the newly registered total.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                          r_irq <= 1'b0;
    else if (clear)                                        r_irq <= 1'b0;
    else if ((thresh != '0) && (w_total_d >= thresh))      r_irq <= 1'b1;
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  assign total_count = r_total;
  assign ch_count    = r_ch_count;
  assign overflow    = r_ovf;
  assign snap_count  = r_snap_count;
  assign snap_valid  = r_snap_valid;

endmodule

// File: tb/tb_bit_flip_counter_array.sv
// Self-checking bench for bit_flip_counter_array (DATA_W=8, COUNT_W=4, SYNC_STAGES=2).
module tb_bit_flip_counter_array;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned COUNT_W     = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned SEL_W       = 3;
  localparam int          CMAX        = (1 << COUNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               clear;
  logic [1:0]         mode;
  logic               saturate;
  logic [DATA_W-1:0]  data_in;
  logic [SEL_W-1:0]   ch_sel;
  logic [COUNT_W-1:0] total_count;
  logic [COUNT_W-1:0] ch_count;
  logic               overflow;
  logic               snap_req;
  logic [COUNT_W-1:0] snap_count;
  logic               snap_valid;
  logic [COUNT_W-1:0] thresh;
  logic               irq;

  int checks = 0;
  int errors = 0;

  bit exp_irq_on;

  bit_flip_counter_array #(
    .DATA_W      (DATA_W),
    .COUNT_W     (COUNT_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .mode        (mode),
    .saturate    (saturate),
    .data_in     (data_in),
    .ch_sel      (ch_sel),
    .total_count (total_count),
    .ch_count    (ch_count),
    .overflow    (overflow),
    .snap_req    (snap_req),
    .snap_count  (snap_count),
    .snap_valid  (snap_valid),
    .thresh      (thresh),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] m_pipe [$];   // bus values still inside the synchroniser
  logic [DATA_W-1:0] m_prev;
  bit                m_primed;
  int                m_age;        // edges since reset (saturating)
  int                m_total;
  int                m_cnt [DATA_W];
  int                m_chc;
  bit                m_ovf;
  bit                m_irq;
  int                sb_q [$];     // expected snapshot values

  function automatic int model_add(int cur, int inc, bit sat, output bit wrapped);
    int sum;
    sum = cur + inc;
    wrapped = (sum > CMAX);
    if (!wrapped) return sum;
    if (sat) return CMAX;
    return sum % (CMAX + 1);
  endfunction

  function automatic void model_reset();
    m_pipe.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) m_pipe.push_back('0);
    m_prev = '0; m_primed = 0; m_age = 0;
    m_total = 0; m_chc = 0; m_ovf = 0; m_irq = 0;
    for (int i = 0; i < int'(DATA_W); i++) m_cnt[i] = 0;
    sb_q.delete();
  endfunction

  // One rising edge with the inputs currently driven.
  function automatic void model_edge();
    logic [DATA_W-1:0] s;
    int n;
    bit w;
    s = m_pipe.pop_front();
    m_pipe.push_back(data_in);
    if (snap_req) sb_q.push_back(m_total);
    m_chc = clear ? 0 : ((int'(ch_sel) < int'(DATA_W)) ? m_cnt[ch_sel] : 0);
    if (clear) begin
      m_total = 0; m_ovf = 0; m_irq = 0; m_primed = 0; m_prev = '0;
      for (int i = 0; i < int'(DATA_W); i++) m_cnt[i] = 0;
    end else begin
      if (m_primed && enable) begin
        n = 0;
        for (int i = 0; i < int'(DATA_W); i++) begin
          bit rose, fell, hit;
          rose = !m_prev[i] && s[i];
          fell = m_prev[i] && !s[i];
          case (mode)
            2'b00:   hit = rose || fell;
            2'b01:   hit = rose;
            2'b10:   hit = fell;
            default: hit = 0;
          endcase
          if (hit) begin
            n++;
            m_cnt[i] = model_add(m_cnt[i], 1, saturate, w);
            if (w) m_ovf = 1;
          end
        end
        m_total = model_add(m_total, n, saturate, w);
        if (w) m_ovf = 1;
      end
      if (!m_primed && m_age >= int'(SYNC_STAGES)) m_primed = 1;
      m_prev = s;
      if (exp_irq_on && thresh != 0 && m_total >= int'(thresh)) m_irq = 1;
    end
    if (m_age < int'(SYNC_STAGES)) m_age++;
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_total"}, 32'(total_count), 32'(m_total));
    chk({tag, "_ovf"},   32'(overflow),    32'(m_ovf));
    chk({tag, "_ch"},    32'(ch_count),    32'(m_chc));
    chk({tag, "_irq"},   32'(irq),         32'(m_irq));
  endtask

  // Snapshot scoreboard monitor.
  always @(negedge clk) begin
    int e;
    if (reset_n && snap_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL snap_unexpected actual=%0d required=none", snap_count);
      end else begin
        e = sb_q.pop_front();
        if (int'(snap_count) != e) begin
          errors++;
          $display("FAIL snap_count actual=%0d required=%0d", snap_count, e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic settle(input int n);
    repeat (n) cyc();
  endtask

  task automatic toggle(input int b);
    data_in[b] = ~data_in[b];
    cyc();
  endtask

  task automatic do_clear();
    clear = 1; cyc(); clear = 0; cyc();
  endtask

  initial begin
`ifdef BFC_THRESH_IRQ_EN
    exp_irq_on = 1;
`else
    exp_irq_on = 0;
`endif
    reset_n = 0; enable = 1; clear = 0; mode = 2'b00; saturate = 0;
    data_in = 8'hFF; ch_sel = '0; snap_req = 0; thresh = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_total", 32'(total_count), 0);
    chk("rst_snap",  32'(snap_count), 0);
    chk("rst_sv",    32'(snap_valid), 0);
    check_state("rst");
    reset_n = 1;

    // Power-on bus value must not be counted.
    settle(10);
    chk("prime_total", 32'(total_count), 0);
    check_state("prime");

    // Both-edge toggle pattern and per-channel readout.
    data_in = 8'h00; settle(4);
    do_clear(); settle(2);
    data_in = 8'h0F; settle(3);
    data_in = 8'h00; settle(4);
    chk("both_total", 32'(total_count), 8);
    check_state("both");
    for (int c = 0; c < 5; c++) begin
      ch_sel = SEL_W'(c); settle(2);
      chk("ch_count", 32'(ch_count), (c < 4) ? 2 : 0);
    end
    mode = 2'b01; do_clear();
    data_in = 8'h0F; settle(3);
    data_in = 8'h00; settle(4);
    chk("rise_total", 32'(total_count), 4);
    check_state("rise");

    // Wrap and saturate with 17 single-bit flips.
    mode = 2'b00; saturate = 0; ch_sel = '0; do_clear();
    for (int i = 0; i < 17; i++) toggle(0);
    settle(3);
    chk("wrap_total", 32'(total_count), 1);
    chk("wrap_ovf",   32'(overflow), 1);
    check_state("wrap");
    saturate = 1; do_clear();
    for (int i = 0; i < 17; i++) toggle(0);
    settle(3);
    chk("sat_total", 32'(total_count), 15);
    chk("sat_ovf",   32'(overflow), 1);
    check_state("sat");

    // Disabled toggling must not leak into the count.
    saturate = 0; do_clear();
    for (int i = 0; i < 3; i++) toggle(1);
    settle(3);
    enable = 0;
    for (int i = 0; i < 5; i++) begin toggle(2); cyc(); end
    settle(3);
    enable = 1; settle(5);
    chk("en_total", 32'(total_count), 3);
    check_state("en");

    // Snapshot together with clear.
    do_clear();
    for (int i = 0; i < 7; i++) toggle(3);
    settle(3);
    snap_req = 1; clear = 1; cyc();
    chk("snapclr_sv",    32'(snap_valid), 1);
    chk("snapclr_count", 32'(snap_count), 7);
    chk("snapclr_total", 32'(total_count), 0);
    snap_req = 0; clear = 0; cyc();
    chk("snapclr_sv_drop", 32'(snap_valid), 0);
    toggle(4); settle(3);
    chk("reprime_total", 32'(total_count), 1);
    snap_req = 1; settle(2); snap_req = 0; cyc();

    // Threshold interrupt.
    do_clear(); thresh = 4'd3;
    for (int i = 0; i < 3; i++) toggle(5);
    for (int i = 0; i < 4; i++) begin cyc(); check_state("irq_ramp"); end
    chk("irq_hit", 32'(irq), exp_irq_on ? 1 : 0);
    for (int i = 0; i < 2; i++) toggle(5);
    settle(3);
    chk("irq_sticky", 32'(irq), exp_irq_on ? 1 : 0);
    clear = 1; cyc(); clear = 0;
    chk("irq_clear", 32'(irq), 0);
    cyc();

    // Randomised traffic, checked every cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) data_in = DATA_W'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 49) == 0) saturate = ~saturate;
      enable   = ($urandom_range(0, 9) != 0);
      clear    = ($urandom_range(0, 39) == 0);
      snap_req = ($urandom_range(0, 7) == 0);
      ch_sel   = SEL_W'($urandom);
      thresh   = COUNT_W'($urandom);
      cyc();
      check_state("rand");
    end
    clear = 0; snap_req = 0; enable = 1; mode = 2'b00;
    settle(2);

    // Reset while a snapshot pulse is pending.
    toggle(6); settle(3);
    snap_req = 1;
    @(posedge clk);
    model_edge();
    #1 reset_n = 0;
    model_reset();
    snap_req = 0;
    @(negedge clk);
    chk("midrst_sv",    32'(snap_valid), 0);
    chk("midrst_total", 32'(total_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;
    settle(6);
    check_state("post_rst");

    chk("snap_pending", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
